// File: rtl/buzzer_tone_gen_pkg.sv
// Shared definitions for the piezo buzzer tone generator.
// State encoding, half-period helper and pin polarity default.
package buzzer_tone_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    TONE = 1'b1
  } state_e;

  localparam bit ACTIVE_LOW_DEF = 1'b0;

  function automatic int half_period(
    input int clk_freq,
    input int tone_freq
  );
    return clk_freq / (2 * tone_freq);
  endfunction

endpackage

// File: rtl/buzzer_tone_gen_tone_half_timer.sv
// Half-period timer for the buzzer tone generator.
// Counts 0..HALF_PERIOD-1 while enabled and pulses wrap on the last count.
module tone_half_timer #(
  parameter int HALF_PERIOD = 12500,
  parameter int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic wrap
);

  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] half_cnt;

  assign wrap = en & (half_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
    end else if (clear) begin
      half_cnt <= '0;
    end else if (en) begin
      if (wrap) begin
        half_cnt <= '0;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Piezo buzzer tone generator: fixed-frequency square wave with a
// minimum beep length, period-aligned stops and a hard disable.
module buzzer_tone_gen
  import buzzer_tone_gen_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TONE_FREQ   = 2_000,
  parameter int MIN_PERIODS = 20,
  parameter bit ACTIVE_LOW  = ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_en,
  input  logic ctrl_buzz,
  output logic buzzer_out,
  output logic busy
);

  localparam int HALF_PERIOD = half_period(CLK_FREQ, TONE_FREQ);
  localparam int PW = (MIN_PERIODS > 0) ? $clog2(MIN_PERIODS + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(MIN_PERIODS);

  generate
    if (HALF_PERIOD < 2) begin : g_bad_half
      $error("buzzer_tone_gen: HALF_PERIOD must be at least 2");
    end
  endgenerate

  state_e        state;
  state_e        state_nxt;
  logic          phase;
  logic          phase_nxt;
  logic [PW-1:0] period_cnt;
  logic [PW-1:0] period_nxt;
  logic [PW-1:0] period_inc;
  logic          req;
  logic          clr;
  logic          wrap;
  logic          done_ok;

  assign req = ctrl_en & ctrl_buzz;
  assign busy = (state != IDLE);

  // Saturating count; done_ok looks at the count including this period.
  assign period_inc = (period_cnt < PMAX) ? period_cnt + 1'b1 : period_cnt;
  assign done_ok = (int'(period_cnt) + 1) >= MIN_PERIODS;

  tone_half_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .en    (state == TONE),
    .wrap  (wrap)
  );

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    period_nxt = period_cnt;
    clr        = 1'b0;
    unique case (state)
      IDLE: begin
        phase_nxt  = 1'b0;
        period_nxt = '0;
        clr        = 1'b1;
        if (req) begin
          state_nxt = TONE;
          phase_nxt = 1'b1;
        end
      end
      TONE: begin
        unique case (1'b1)
          !ctrl_en: begin
            state_nxt  = IDLE;
            phase_nxt  = 1'b0;
            period_nxt = '0;
            clr        = 1'b1;
          end
          ctrl_en && wrap && phase: begin
            phase_nxt = 1'b0;
          end
          ctrl_en && wrap && !phase: begin
            if (!ctrl_buzz && done_ok) begin
              state_nxt  = IDLE;
              phase_nxt  = 1'b0;
              period_nxt = '0;
              clr        = 1'b1;
            end else begin
              phase_nxt  = 1'b1;
              period_nxt = period_inc;
            end
          end
          default: begin
          end
        endcase
      end
      default: begin
        state_nxt  = IDLE;
        phase_nxt  = 1'b0;
        period_nxt = '0;
        clr        = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      period_cnt <= '0;
      buzzer_out <= ACTIVE_LOW;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      period_cnt <= period_nxt;
      buzzer_out <= ACTIVE_LOW ^ ((state_nxt == TONE) & phase_nxt);
    end
  end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen (HALF_PERIOD=5, MIN_PERIODS=2).
// A second instance covers the active-low pin polarity.
module tb_buzzer_tone_gen;

  logic clk;
  logic rst;
  logic ctrl_en;
  logic ctrl_buzz;
  logic buzzer_out;
  logic busy;

  logic rst_al;
  logic en_al;
  logic buzz_al;
  logic pin_al;
  logic busy_al;

  int total;
  int passed;

  buzzer_tone_gen #(
    .CLK_FREQ    (1000),
    .TONE_FREQ   (100),
    .MIN_PERIODS (2),
    .ACTIVE_LOW  (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_en    (ctrl_en),
    .ctrl_buzz  (ctrl_buzz),
    .buzzer_out (buzzer_out),
    .busy       (busy)
  );

  buzzer_tone_gen #(
    .CLK_FREQ    (1000),
    .TONE_FREQ   (100),
    .MIN_PERIODS (2),
    .ACTIVE_LOW  (1'b1)
  ) dut_al (
    .clk        (clk),
    .rst        (rst_al),
    .ctrl_en    (en_al),
    .ctrl_buzz  (buzz_al),
    .buzzer_out (pin_al),
    .busy       (busy_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rst_al = 1'b1;
    ctrl_en = 1'b0;
    ctrl_buzz = 1'b0;
    en_al = 1'b0;
    buzz_al = 1'b0;
    tick();
    tick();
    total++;
    if (buzzer_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_state pin=%b busy=%b want 0/0", buzzer_out, busy);
    else passed++;
    rst = 1'b0;
    rst_al = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (buzzer_out !== 1'b0 || busy !== 1'b0)
        $display("FAIL post_reset_idle c%0d pin=%b busy=%b want 0/0", k, buzzer_out, busy);
      else passed++;
    end
  endtask

  task automatic test_continuous;
    ctrl_en = 1'b1;
    ctrl_buzz = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      total++;
      if (buzzer_out !== ((k % 10) < 5) || busy !== 1'b1)
        $display("FAIL continuous e%0d pin=%b busy=%b want %b/1", k, buzzer_out, busy, (k % 10) < 5);
      else passed++;
    end
    ctrl_buzz = 1'b0;
    tick();
    total++;
    if (buzzer_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL continuous_stop pin=%b busy=%b want 0/0", buzzer_out, busy);
    else passed++;
  endtask

  task automatic test_pulse;
    ctrl_buzz = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) ctrl_buzz = 1'b0;
      total++;
      if (buzzer_out !== ((k % 10) < 5) || busy !== 1'b1)
        $display("FAIL pulse e%0d pin=%b busy=%b want %b/1", k, buzzer_out, busy, (k % 10) < 5);
      else passed++;
    end
    tick();
    total++;
    if (buzzer_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL pulse_end e20 pin=%b busy=%b want 0/0", buzzer_out, busy);
    else passed++;
  endtask

  task automatic test_back_to_back;
    ctrl_buzz = 1'b1;
    tick();
    ctrl_buzz = 1'b0;
    total++;
    if (buzzer_out !== 1'b1 || busy !== 1'b1)
      $display("FAIL rearm_start pin=%b busy=%b want 1/1", buzzer_out, busy);
    else passed++;
    for (int k = 1; k < 20; k++) tick();
    total++;
    if (busy !== 1'b1)
      $display("FAIL rearm_min_len e19 busy=%b want 1", busy);
    else passed++;
    tick();
    total++;
    if (buzzer_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL rearm_end e20 pin=%b busy=%b want 0/0", buzzer_out, busy);
    else passed++;
  endtask

  task automatic test_graceful;
    ctrl_buzz = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (k == 53) ctrl_buzz = 1'b0;
      total++;
      if (buzzer_out !== ((k % 10) < 5) || busy !== 1'b1)
        $display("FAIL graceful e%0d pin=%b busy=%b want %b/1", k, buzzer_out, busy, (k % 10) < 5);
      else passed++;
    end
    tick();
    total++;
    if (buzzer_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL graceful_end e60 pin=%b busy=%b want 0/0", buzzer_out, busy);
    else passed++;
  endtask

  task automatic test_hard_stop;
    bit idle_seen;
    ctrl_en = 1'b1;
    ctrl_buzz = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (buzzer_out !== ((k % 10) < 5) || busy !== 1'b1)
        $display("FAIL hard_pre e%0d pin=%b busy=%b want %b/1", k, buzzer_out, busy, (k % 10) < 5);
      else passed++;
    end
    ctrl_en = 1'b0;
    tick();
    total++;
    if (buzzer_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL hard_stop pin=%b busy=%b want 0/0", buzzer_out, busy);
    else passed++;
    ctrl_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (buzzer_out !== (k < 5) || busy !== 1'b1)
        $display("FAIL hard_restart e%0d pin=%b busy=%b want %b/1", k, buzzer_out, busy, k < 5);
      else passed++;
    end
    ctrl_buzz = 1'b0;
    idle_seen = 1'b0;
    for (int k = 0; k < 30 && !idle_seen; k++) begin
      tick();
      if (busy === 1'b0) idle_seen = 1'b1;
    end
    total++;
    if (!idle_seen || buzzer_out !== 1'b0)
      $display("FAIL hard_drain busy=%b pin=%b want idle 0/0 within 30", busy, buzzer_out);
    else passed++;
  endtask

  task automatic test_active_low;
    total++;
    if (pin_al !== 1'b1 || busy_al !== 1'b0)
      $display("FAIL al_idle pin=%b busy=%b want 1/0", pin_al, busy_al);
    else passed++;
    en_al = 1'b1;
    buzz_al = 1'b1;
    tick();
    total++;
    if (pin_al !== 1'b0 || busy_al !== 1'b1)
      $display("FAIL al_active pin=%b busy=%b want 0/1", pin_al, busy_al);
    else passed++;
    tick();
    tick();
    #3;
    rst_al = 1'b1;
    #1;
    total++;
    if (pin_al !== 1'b1 || busy_al !== 1'b0)
      $display("FAIL al_async_rst pin=%b busy=%b want 1/0", pin_al, busy_al);
    else passed++;
    buzz_al = 1'b0;
    en_al = 1'b0;
    tick();
    rst_al = 1'b0;
    tick();
    total++;
    if (pin_al !== 1'b1 || busy_al !== 1'b0)
      $display("FAIL al_post_rst pin=%b busy=%b want 1/0", pin_al, busy_al);
    else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_continuous();
    test_pulse();
    test_back_to_back();
    test_graceful();
    test_hard_stop();
    test_active_low();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
